// File: rtl/psk_frame_source.sv
// Framed BPSK/DBPSK symbol source: alternating preamble, 16-bit sync word, PN9 payload.
// Latency: first symbol appears one cycle after en is sampled high in IDLE; all outputs registered.
// Backpressure: none, free-running at DIV clocks per symbol; en only sampled on frame boundaries.
module psk_frame_source #(
   parameter int          DIV          = 32,
   parameter int          PREAMBLE_LEN = 32,
   parameter logic [15:0] SYNC_WORD    = 16'hEB90,
   parameter int          PAYLOAD_LEN  = 256
) (
   input  logic        clk_32d768M,
   input  logic        rst_32d768M,
   input  logic        en,
   output logic        sym_stb,
   output logic        sym_bit,
   output logic        sym_diff,
   output logic        frame_start,
   output logic        busy,
   output logic [15:0] frame_cnt
);

   localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
   localparam logic [15:0] SYN_LAST = 16'd15;
   localparam logic [15:0] PAY_LAST = 16'(PAYLOAD_LEN - 1);
   localparam logic [8:0]  PN9_SEED = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      SYNC     = 2'd2,
      PAYLOAD  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] div_cnt;
   logic [15:0] sym_cnt;
   logic [15:0] sym_cnt_nxt;
   logic [8:0]  lfsr;
   logic        sym_end;
   logic        last_sym;
   logic        frame_done;
   logic        frame_new;
   logic        sym_new;
   logic        bit_nxt;
   logic [3:0]  sync_idx;

   // A symbol ends on the last divider cycle of any active state.
   assign sym_end = (state != IDLE) && (div_cnt == DIV_LAST);

   // State register.
   always_ff @(posedge clk_32d768M or posedge rst_32d768M) begin
      if (rst_32d768M) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: phases advance only at the end of their last symbol.
   always_comb begin
      state_nxt = state;
      last_sym  = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nxt = PREAMBLE;
         end
         PREAMBLE: begin
            last_sym = (sym_cnt == PRE_LAST);
            if (sym_end && last_sym) state_nxt = SYNC;
         end
         SYNC: begin
            last_sym = (sym_cnt == SYN_LAST);
            if (sym_end && last_sym) state_nxt = PAYLOAD;
         end
         PAYLOAD: begin
            last_sym = (sym_cnt == PAY_LAST);
            if (sym_end && last_sym) state_nxt = en ? PREAMBLE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: decide whether a symbol starts next cycle and which bit it carries.
   always_comb begin
      frame_done = sym_end && last_sym && (state == PAYLOAD);
      frame_new  = en && ((state == IDLE) || frame_done);
      sym_new    = (state == IDLE) ? en : (sym_end && (state_nxt != IDLE));

      if ((state_nxt != state) || frame_new) begin
         sym_cnt_nxt = 16'd0;
      end else if (sym_end) begin
         sym_cnt_nxt = sym_cnt + 16'd1;
      end else begin
         sym_cnt_nxt = sym_cnt;
      end

      sync_idx = 4'd15 - sym_cnt_nxt[3:0];
      case (state_nxt)
         PREAMBLE: bit_nxt = ~sym_cnt_nxt[0];
         SYNC:     bit_nxt = SYNC_WORD[sync_idx];
         PAYLOAD:  bit_nxt = lfsr[8];
         default:  bit_nxt = sym_bit;
      endcase
   end

   // Registered datapath: divider, symbol index, PN9, outputs and frame counter.
   always_ff @(posedge clk_32d768M or posedge rst_32d768M) begin
      if (rst_32d768M) begin
         div_cnt     <= 16'd0;
         sym_cnt     <= 16'd0;
         lfsr        <= PN9_SEED;
         sym_stb     <= 1'b0;
         sym_bit     <= 1'b0;
         sym_diff    <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         frame_cnt   <= 16'd0;
      end else begin
         sym_stb     <= sym_new;
         frame_start <= frame_new;
         busy        <= (state_nxt != IDLE);
         sym_cnt     <= sym_cnt_nxt;
         div_cnt     <= ((state_nxt == IDLE) || sym_new) ? 16'd0 : div_cnt + 16'd1;

         if (sym_new) begin
            sym_bit  <= bit_nxt;
            // Differential history restarts only when leaving IDLE; back-to-back frames continue it.
            sym_diff <= ((state == IDLE) ? 1'b0 : sym_diff) ^ bit_nxt;
         end

         // Seed at every frame start; step once per payload symbol after its bit is taken.
         if (frame_new) begin
            lfsr <= PN9_SEED;
         end else if (sym_new && (state_nxt == PAYLOAD)) begin
            lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
         end

         if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule

// File: doc/psk_frame_source.md
PSK_FRAME_SOURCE -- requirements
Module: psk_frame_source

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DIV, default 32, SHALL set clocks per symbol (32.768 MHz / 32 = 1.024 Msym/s); legal range 2..65535.
REQ-003 Parameter PREAMBLE_LEN, default 32, SHALL set the preamble length in symbols; legal range 1..65535.
REQ-004 Parameter SYNC_WORD, default 16'hEB90, SHALL be the 16-bit sync word, sent MSB first.
REQ-005 Parameter PAYLOAD_LEN, default 256, SHALL set the payload length in symbols; legal range 1..65535.
REQ-006 Port clk_32d768M  in  1  SHALL be the block clock, on the 32.768 MHz domain.
REQ-007 Port rst_32d768M  in  1  SHALL be the asynchronous active-high reset.
REQ-008 Port en  in  1  SHALL be the run request, sampled on frame boundaries only.
REQ-009 Port sym_stb  out  1  SHALL pulse for one cycle on the first cycle of every symbol.
REQ-010 Port sym_bit  out  1  SHALL be the raw symbol bit.
REQ-011 Port sym_diff  out  1  SHALL be the differentially encoded bit for DBPSK.
REQ-012 Port frame_start  out  1  SHALL pulse for one cycle, coincident with sym_stb, on the first preamble symbol.
REQ-013 Port busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-014 Port frame_cnt  out  16  SHALL count completed frames, wrapping from 16'hFFFF to 0.

Function
REQ-015 The FSM SHALL have states IDLE, PREAMBLE, SYNC and PAYLOAD.
REQ-016 IDLE with en=1 SHALL move to PREAMBLE on the next cycle; that cycle SHALL assert sym_stb=1 and frame_start=1 and present the first preamble bit.
REQ-017 The divider counter SHALL run 0..DIV-1 while not in IDLE, and SHALL be 0 on each sym_stb cycle.
REQ-018 A new symbol SHALL begin when the counter wraps; sym_bit and sym_diff SHALL change only on sym_stb cycles.
REQ-019 The preamble SHALL alternate 1,0,1,0,... starting with 1 and SHALL last PREAMBLE_LEN symbols, then the FSM SHALL move to SYNC.
REQ-020 SYNC SHALL emit SYNC_WORD[15] down to SYNC_WORD[0], 16 symbols, then the FSM SHALL move to PAYLOAD.
REQ-021 PAYLOAD SHALL use a PN9 generator (x^9+x^5+1) as follows:
- seed 9'h1FF at the start of every frame
- output bit = lfsr[8]
- next lfsr = {lfsr[7:0], lfsr[8]^lfsr[4]}
- one step per symbol
- PAYLOAD_LEN symbols in total.
REQ-022 sym_diff SHALL equal the previous sym_diff XOR sym_bit; its history SHALL be cleared to 0 only on leaving IDLE and SHALL continue across back-to-back frames.
REQ-023 At the end of the last payload symbol (counter = DIV-1), frame_cnt SHALL increment.
REQ-024 At that same point, en=1 SHALL start the next frame on the next cycle with no gap (sym_stb and frame_start asserted); en=0 SHALL return the FSM to IDLE.
REQ-025 en deasserted mid-frame SHALL NOT truncate the frame; the current frame SHALL complete.
REQ-026 en SHALL be ignored in every state other than IDLE and the final payload cycle.
REQ-027 In IDLE, sym_stb and frame_start SHALL be 0, and sym_bit and sym_diff SHALL hold their last values.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 Reset asserted SHALL, asynchronously and immediately, set the following, regardless of state:
- FSM = IDLE
- counters, sym_stb, sym_bit, sym_diff, frame_start, busy = 0
- frame_cnt = 0
- lfsr = 9'h1FF.
REQ-030 After reset deasserts, the block SHALL start a frame only upon en=1 sampled in IDLE.

Verification (DIV=4, PREAMBLE_LEN=4, PAYLOAD_LEN=16)
REQ-031 Reset check: assert reset with en=1 -> all outputs 0 with no clock edge required; after release with en=0 -> busy stays 0.
REQ-032 Single-cycle en pulse -> exactly one frame of 36 symbols over 144 cycles, and:
- sym_bit sequence 1,0,1,0 | 1110 1011 1001 0000 | nine 1s, five 0s, ...
- frame_cnt = 1 and busy = 0 afterwards.
REQ-033 Differential check on the first preamble -> sym_diff = 1,1,0,0.
REQ-034 en held high for 3 frames ->
- sym_stb strictly every 4 cycles with no inter-frame gap
- frame_start every 144 cycles
- frame_cnt = 3 after the third frame
- PN9 restarts at nine 1s each frame.
REQ-035 en dropped during SYNC -> frame completes in full, then IDLE; exactly one frame_cnt increment.
REQ-036 Reset pulsed mid-PAYLOAD -> outputs 0 immediately; the next en gives a fresh frame starting at preamble bit 1 with the PN9 sequence from seed.
